fifo_write_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port of one `fifo` instance among `no_of_requesters` producers. Each cycle it selects at most one requesting producer, drives the FIFO `write`/`write_data` pair, and withholds every grant while the FIFO reports `full`. It sits directly in front of the FIFO; its outputs connect straight to the FIFO write side, and its `full` input connects to the FIFO `full` output.

---
 rtl/fifo_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Brief    : Round-robin arbiter sharing one FIFO write port among producers.
//            Define FIFO_ARB_BURST_LOCK_EN to enable the per-owner burst lock.
// Revision : 1.0 - initial release
// ============================================================================

module fifo_write_arbiter #(
    parameter int no_of_requesters = 4,
    parameter int bits_per_word    = 8,
    parameter int max_burst        = 4
) (
    input  logic                                      clk,
    input  logic                                      areset,
    input  logic [no_of_requesters-1:0]               req,
    input  logic [no_of_requesters*bits_per_word-1:0] req_data,
    input  logic                                      full,
    output logic [no_of_requesters-1:0]               grant,
    output logic                                      write,
    output logic [bits_per_word-1:0]                  write_data,
    output logic                                      lock_active,
    output logic [$clog2(no_of_requesters)-1:0]       lock_owner
);

    localparam int c_IDX_W = $clog2(no_of_requesters);

    generate
        if (no_of_requesters < 2 || max_burst < 1) begin : g_param_check
            $error("fifo_write_arbiter: no_of_requesters must be >= 2 and max_burst >= 1");
        end
    endgenerate

    // Explicit wrap so non-power-of-two requester counts behave correctly.
    function automatic logic [c_IDX_W-1:0] wrap_inc(input logic [c_IDX_W-1:0] idx);
        logic [c_IDX_W-1:0] nxt;
        if (int'(idx) == no_of_requesters - 1) nxt = '0;
        else                                    nxt = idx + c_IDX_W'(1);
        return nxt;
    endfunction

    function automatic logic [c_IDX_W-1:0] rr_idx(input logic [c_IDX_W-1:0] base, input int k);
        int pos;
        pos = int'(base) + k;
        if (pos >= no_of_requesters) pos = pos - no_of_requesters;
        return c_IDX_W'(pos);
    endfunction

    logic [c_IDX_W-1:0] ptr_q;
    logic [c_IDX_W-1:0] ptr_d;
    logic [c_IDX_W-1:0] search_start;
    logic [c_IDX_W-1:0] sel_idx;
    logic [c_IDX_W-1:0] win_idx;
    logic               sel_found;
    logic               owner_hold;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < no_of_requesters; k++) begin
            if (!sel_found && req[rr_idx(search_start, k)]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx(search_start, k);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (!areset && !full && (owner_hold || sel_found)) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign write = |grant;

    always_comb begin
        write_data = '0;
        for (int i = 0; i < no_of_requesters; i++) begin
            if (grant[i]) begin
                write_data = write_data | req_data[i*bits_per_word +: bits_per_word];
            end
        end
    end

`ifdef FIFO_ARB_BURST_LOCK_EN

    localparam int          c_CNT_W     = $clog2(max_burst + 1);
    localparam logic [0:0]  c_ST_IDLE   = 1'b0;
    localparam logic [0:0]  c_ST_LOCKED = 1'b1;

    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic [c_IDX_W-1:0] owner_q;
    logic [c_IDX_W-1:0] owner_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // A locked owner that drops req releases the lock in the same cycle.
    assign owner_hold   = (state_q == c_ST_LOCKED) && req[owner_q];
    assign search_start = (state_q == c_ST_LOCKED) ? wrap_inc(owner_q) : ptr_q;
    assign win_idx      = owner_hold ? owner_q : sel_idx;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= c_ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (write) begin
            ptr_d = wrap_inc(win_idx);
            if (owner_hold) begin
                if (cnt_q == c_CNT_W'(max_burst - 1)) begin
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end else if (max_burst == 1) begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = c_ST_LOCKED;
                owner_d = win_idx;
                cnt_d   = c_CNT_W'(1);
            end
        end else if ((state_q == c_ST_LOCKED) && !full && !req[owner_q]) begin
            state_d = c_ST_IDLE;
            ptr_d   = wrap_inc(owner_q);
            cnt_d   = '0;
        end
    end

    always_comb begin
        lock_active = (state_q == c_ST_LOCKED);
        lock_owner  = owner_q;
    end

`else

    assign owner_hold   = 1'b0;
    assign search_start = ptr_q;
    assign win_idx      = sel_idx;

    always_ff @(posedge clk) begin
        if (areset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (write) ptr_d = wrap_inc(win_idx);
    end

    always_comb begin
        lock_active = 1'b0;
        lock_owner  = '0;
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Brief    : Directed self-checking bench for fifo_write_arbiter (N=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           areset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data;
    logic           full = 1'b0;
    logic [N-1:0]   grant;
    logic           write;
    logic [W-1:0]   write_data;
    logic           lock_active;
    logic [1:0]     lock_owner;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] words [N];

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .no_of_requesters (N),
        .bits_per_word    (W),
        .max_burst        (MB)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .req         (req),
        .req_data    (req_data),
        .full        (full),
        .grant       (grant),
        .write       (write),
        .write_data  (write_data),
        .lock_active (lock_active),
        .lock_owner  (lock_owner)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic [N-1:0] r, input logic f, input logic rst);
        @(negedge clk);
        req    = r;
        full   = f;
        areset = rst;
        #1;
    endtask

    // widx < 0 means no write is expected this cycle.
    task automatic chk_out(input string tag, input logic [N-1:0] exp_g, input int widx);
        check_val({tag, "_grant"}, 32'(grant), 32'(exp_g));
        check_val({tag, "_write"}, 32'(write), (widx >= 0) ? 32'd1 : 32'd0);
        check_val({tag, "_data"},  32'(write_data), (widx >= 0) ? 32'(words[widx]) : 32'd0);
    endtask

    initial begin
        int exp_owner;
        words = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
        for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];

        repeat (2) @(posedge clk);
        step(4'b1111, 1'b0, 1'b1);
        chk_out("reset", 4'b0000, -1);
        check_val("reset_lock_active", 32'(lock_active), 32'd0);
        check_val("reset_lock_owner",  32'(lock_owner),  32'd0);

`ifndef FIFO_ARB_BURST_LOCK_EN
        for (int k = 0; k < 6; k++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk_out($sformatf("rot%0d", k), onehot(k % 4), k % 4);
        end
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk_out($sformatf("full_stall%0d", k), 4'b0000, -1);
        end
        step(4'b1111, 1'b0, 1'b0); chk_out("after_full", onehot(2), 2);
        step(4'b1010, 1'b0, 1'b0); chk_out("sparse0", onehot(3), 3);
        step(4'b1010, 1'b0, 1'b0); chk_out("sparse1", onehot(1), 1);
        step(4'b1010, 1'b0, 1'b0); chk_out("sparse2", onehot(3), 3);
        step(4'b0000, 1'b0, 1'b0); chk_out("no_req", 4'b0000, -1);
        step(4'b0110, 1'b0, 1'b0); chk_out("wrap_search", onehot(1), 1);
        step(4'b0111, 1'b1, 1'b0); chk_out("full_dominates", 4'b0000, -1);
        step(4'b0111, 1'b0, 1'b0); chk_out("ptr_held", onehot(2), 2);
        step(4'b1111, 1'b0, 1'b1); chk_out("reset_gate", 4'b0000, -1);
        step(4'b1010, 1'b0, 1'b0); chk_out("post_reset_ptr", onehot(1), 1);
        check_val("nolock_active", 32'(lock_active), 32'd0);
        check_val("nolock_owner",  32'(lock_owner),  32'd0);
`else
        for (int k = 0; k < 12; k++) begin
            exp_owner = ((k / 4) % 2 == 0) ? 0 : 2;
            step(4'b0101, 1'b0, 1'b0);
            chk_out($sformatf("burst%0d", k), onehot(exp_owner), exp_owner);
            if (k % 4 != 0) begin
                check_val($sformatf("burst%0d_owner", k),  32'(lock_owner),  32'(exp_owner));
                check_val($sformatf("burst%0d_active", k), 32'(lock_active), 32'd1);
            end else if (k > 0) begin
                check_val($sformatf("burst%0d_gap", k), 32'(lock_active), 32'd0);
            end
        end

        step(4'b0001, 1'b0, 1'b0); chk_out("early_a0", onehot(0), 0);
        step(4'b0001, 1'b0, 1'b0); chk_out("early_a1", onehot(0), 0);
        check_val("early_locked", 32'(lock_active), 32'd1);
        step(4'b1000, 1'b0, 1'b0); chk_out("early_release", onehot(3), 3);
        step(4'b0000, 1'b0, 1'b0); chk_out("early_idle", 4'b0000, -1);
        check_val("early_new_owner",  32'(lock_owner),  32'd3);
        check_val("early_new_active", 32'(lock_active), 32'd1);
        step(4'b0000, 1'b0, 1'b0);
        check_val("early_unlocked", 32'(lock_active), 32'd0);

        step(4'b0100, 1'b0, 1'b0); chk_out("midrst_w0", onehot(2), 2);
        step(4'b0100, 1'b0, 1'b0); chk_out("midrst_w1", onehot(2), 2);
        check_val("midrst_owner", 32'(lock_owner), 32'd2);
        step(4'b0100, 1'b0, 1'b1); chk_out("midrst_gate", 4'b0000, -1);
        step(4'b1010, 1'b0, 1'b0); chk_out("midrst_after", onehot(1), 1);
        check_val("midrst_active", 32'(lock_active), 32'd0);
        check_val("midrst_owner0", 32'(lock_owner),  32'd0);
        step(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            step(4'b1000, 1'b0, 1'b0);
            chk_out($sformatf("single%0d", k), onehot(3), 3);
            check_val($sformatf("single%0d_active", k), 32'(lock_active), (k % 4 != 0) ? 32'd1 : 32'd0);
        end
        step(4'b1000, 1'b1, 1'b0); chk_out("lock_full", 4'b0000, -1);
        check_val("lock_full_active", 32'(lock_active), 32'd1);
        step(4'b1000, 1'b0, 1'b0); chk_out("lock_resume0", onehot(3), 3);
        step(4'b1000, 1'b0, 1'b0); chk_out("lock_resume1", onehot(3), 3);
        check_val("lock_resume_active", 32'(lock_active), 32'd1);
        step(4'b1000, 1'b0, 1'b0);
        check_val("lock_burst_end", 32'(lock_active), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
